// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the CPU run-control unit.
// State encoding is visible on the `state` output port.
package run_ctrl_pkg;

   localparam int ST_W = 2;

   localparam logic [ST_W-1:0] ST_RESET = 2'd0;
   localparam logic [ST_W-1:0] ST_IDLE  = 2'd1;
   localparam logic [ST_W-1:0] ST_RUN   = 2'd2;
   localparam logic [ST_W-1:0] ST_STOP  = 2'd3;

   typedef enum logic [ST_W-1:0] {
      S_RESET = ST_RESET,
      S_IDLE  = ST_IDLE,
      S_RUN   = ST_RUN,
      S_STOP  = ST_STOP
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/run_controller.sv
// CPU run control: stretched CPU reset, clock enable for run,
// single-step and cycle-limited execution, halt/limit stop.
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int RESET_CYCLES = 4,
   parameter int CNT_WIDTH    = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run_req,
   input  logic                 step_req,
   input  logic                 clr_req,
   input  logic                 halt_in,
   input  logic [CNT_WIDTH-1:0] limit,
   output logic                 cpu_reset_n,
   output logic                 cpu_ce,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [1:0]           state,
   output logic                 halted,
   output logic                 timeout
);

   localparam int SW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [SW-1:0] STR_LAST = SW'(RESET_CYCLES - 1);

   state_e        state_q, state_d;
   logic [SW-1:0] str_q, str_d;
   logic          rstn_q, rstn_d;
   logic          halted_q, halted_d;
   logic          timeout_q, timeout_d;
   logic          pulse_q, pulse_d;
   logic          step_q;

   logic lim_hit;
   logic step_edge;
   logic clr_take;
   logic run_ce;

   assign lim_hit   = (limit != '0) && (cycle_count == limit);
   assign step_edge = step_req & ~step_q;
   assign clr_take  = clr_req & (state_q != S_RESET);
   assign run_ce    = (state_q == S_RUN) & ~halt_in & ~lim_hit;
   assign cpu_ce    = run_ce | pulse_q;

   always_comb begin
      state_d   = state_q;
      str_d     = str_q;
      rstn_d    = rstn_q;
      halted_d  = halted_q;
      timeout_d = timeout_q;
      pulse_d   = 1'b0;
      if (clr_take) begin
         state_d   = S_RESET;
         str_d     = '0;
         rstn_d    = 1'b0;
         halted_d  = 1'b0;
         timeout_d = 1'b0;
      end else begin
         unique case (state_q)
            S_RESET: begin
               rstn_d = 1'b0;
               if (str_q == STR_LAST) begin
                  state_d = S_IDLE;
                  rstn_d  = 1'b1;
               end else begin
                  str_d = str_q + SW'(1);
               end
            end
            S_IDLE: begin
               if (run_req) begin
                  state_d = S_RUN;
               end else if (step_edge) begin
                  if (halt_in) begin
                     state_d  = S_STOP;
                     halted_d = 1'b1;
                  end else if (lim_hit) begin
                     state_d   = S_STOP;
                     timeout_d = 1'b1;
                  end else begin
                     pulse_d = 1'b1;
                  end
               end
            end
            // halt outranks the limit when both arrive together
            S_RUN: begin
               if (halt_in) begin
                  state_d  = S_STOP;
                  halted_d = 1'b1;
               end else if (lim_hit) begin
                  state_d   = S_STOP;
                  timeout_d = 1'b1;
               end else if (!run_req) begin
                  state_d = S_IDLE;
               end
            end
            S_STOP: begin
               state_d = S_STOP;
            end
            default: begin
               state_d = S_RESET;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_RESET;
         str_q     <= '0;
         rstn_q    <= 1'b0;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
         pulse_q   <= 1'b0;
         step_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         str_q     <= str_d;
         rstn_q    <= rstn_d;
         halted_q  <= halted_d;
         timeout_q <= timeout_d;
         pulse_q   <= pulse_d;
         step_q    <= step_req;
      end
   end

   sat_counter #(
      .W (CNT_WIDTH)
   ) u_cnt (
      .clk   (clk),
      .rst_n (reset),
      .en    (cpu_ce),
      .clr   (clr_take),
      .count (cycle_count)
   );

   assign cpu_reset_n = rstn_q;
   assign state       = state_q;
   assign halted      = halted_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: vector table, directed corner
// sequences and random stimulus against a behavioural model.
module tb_run_controller;

   localparam int RC   = 4;
   localparam int CW   = 20;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          run_req, step_req, clr_req, halt_in;
   logic [CW-1:0] limit;
   logic          cpu_reset_n, cpu_ce, halted, timeout;
   logic [CW-1:0] cycle_count;
   logic [1:0]    state;

   logic       run4, step4, clr4, halt4;
   logic [3:0] limit4, cnt4;
   logic       rstn4, ce4, h4, t4;
   logic [1:0] st4;

   int n_cmp = 0;
   int n_bad = 0;
   int n_ce  = 0;

   // behavioural model (states numbered as on the port)
   int m_mode, m_wait, m_cnt;
   bit m_rstn, m_h, m_t, m_prev, m_pulse;

   typedef struct {
      bit run, step, clr, halt;
      int lim;
      int st;
      bit ce;
      int cnt;
      bit rn, h, t;
   } vec_t;

   vec_t tbl[10];

   run_controller #(.RESET_CYCLES(RC), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .run_req(run_req),
      .step_req(step_req), .clr_req(clr_req),
      .halt_in(halt_in), .limit(limit),
      .cpu_reset_n(cpu_reset_n), .cpu_ce(cpu_ce),
      .cycle_count(cycle_count), .state(state),
      .halted(halted), .timeout(timeout)
   );

   run_controller #(.RESET_CYCLES(RC), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .run_req(run4),
      .step_req(step4), .clr_req(clr4),
      .halt_in(halt4), .limit(limit4),
      .cpu_reset_n(rstn4), .cpu_ce(ce4),
      .cycle_count(cnt4), .state(st4),
      .halted(h4), .timeout(t4)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic bit m_lim();
      return (limit != 0) && (m_cnt == int'(limit));
   endfunction

   function automatic bit m_ce();
      return (m_mode == 2 && !halt_in && !m_lim()) || m_pulse;
   endfunction

   task automatic m_reset();
      m_mode  = 0;
      m_wait  = 0;
      m_cnt   = 0;
      m_rstn  = 0;
      m_h     = 0;
      m_t     = 0;
      m_prev  = 0;
      m_pulse = 0;
   endtask

   task automatic m_edge();
      bit ce, lh, se, np;
      ce = m_ce();
      lh = m_lim();
      se = step_req && !m_prev;
      np = 0;
      m_prev = step_req;
      if (clr_req && m_mode != 0) begin
         m_mode = 0;
         m_wait = 0;
         m_rstn = 0;
         m_h    = 0;
         m_t    = 0;
         m_cnt  = 0;
      end else begin
         if (ce && m_cnt < MAXC) m_cnt++;
         if (m_mode == 0) begin
            m_wait++;
            if (m_wait == RC) begin
               m_mode = 1;
               m_rstn = 1;
            end
         end else if (m_mode == 1) begin
            if (run_req) m_mode = 2;
            else if (se && halt_in) begin m_mode = 3; m_h = 1; end
            else if (se && lh) begin m_mode = 3; m_t = 1; end
            else if (se) np = 1;
         end else if (m_mode == 2) begin
            if (halt_in) begin m_mode = 3; m_h = 1; end
            else if (lh) begin m_mode = 3; m_t = 1; end
            else if (!run_req) m_mode = 1;
         end
      end
      m_pulse = np;
   endtask

   task automatic settle();
      #2;
      chk("state", state, m_mode);
      chk("cpu_reset_n", cpu_reset_n, m_rstn);
      chk("cpu_ce", cpu_ce, m_ce());
      chk("cycle_count", cycle_count, m_cnt);
      chk("halted", halted, m_h);
      chk("timeout", timeout, m_t);
      if (cpu_ce) n_ce++;
   endtask

   task automatic adv();
      m_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      settle();
      adv();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && state != 2'd1; i++) cyc();
      chk("reach_idle", state, 1);
   endtask

   initial begin
      int k;
      tbl[0] = '{0,0,0,0,3, 1,0,0,1,0,0};
      tbl[1] = '{1,0,0,0,3, 1,0,0,1,0,0};
      tbl[2] = '{1,0,0,0,3, 2,1,0,1,0,0};
      tbl[3] = '{1,0,0,0,3, 2,1,1,1,0,0};
      tbl[4] = '{0,0,0,0,3, 2,1,2,1,0,0};
      tbl[5] = '{0,0,0,0,3, 1,0,3,1,0,0};
      tbl[6] = '{0,1,0,0,3, 1,0,3,1,0,0};
      tbl[7] = '{0,0,0,0,3, 3,0,3,1,0,1};
      tbl[8] = '{0,0,1,0,3, 3,0,3,1,0,1};
      tbl[9] = '{0,0,0,0,3, 0,0,0,0,0,0};

      reset = 0; run_req = 0; step_req = 0;
      clr_req = 0; halt_in = 0; limit = '0;
      run4 = 0; step4 = 0; clr4 = 0; halt4 = 0; limit4 = '0;
      m_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_state", state, 0);
      chk("rst_rstn", cpu_reset_n, 0);
      chk("rst_ce", cpu_ce, 0);
      chk("rst_count", cycle_count, 0);
      reset = 1;

      // reset stretch length
      k = 0;
      while (cpu_reset_n !== 1'b1 && k < 20) begin
         cyc();
         k++;
      end
      chk("stretch_edges", k, RC);
      chk("post_rst_state", state, 1);
      chk("post_rst_ce", cpu_ce, 0);
      chk("post_rst_flags", {halted, timeout}, 0);

      // vector table
      foreach (tbl[i]) begin
         run_req = tbl[i].run; step_req = tbl[i].step;
         clr_req = tbl[i].clr; halt_in = tbl[i].halt;
         limit = CW'(tbl[i].lim);
         settle();
         chk("tbl_state", state, tbl[i].st);
         chk("tbl_ce", cpu_ce, tbl[i].ce);
         chk("tbl_count", cycle_count, tbl[i].cnt);
         chk("tbl_rstn", cpu_reset_n, tbl[i].rn);
         chk("tbl_flags", {halted, timeout}, {tbl[i].h, tbl[i].t});
         adv();
      end
      clr_req = 0;
      wait_idle();

      // run to a limit of 10
      limit = CW'(10); run_req = 1; n_ce = 0;
      for (int i = 0; i < 50 && state != 2'd3; i++) cyc();
      chk("lim_ce_cycles", n_ce, 10);
      chk("lim_count", cycle_count, 10);
      chk("lim_state", state, 3);
      chk("lim_flags", {halted, timeout}, 2'b01);

      // clear from STOP restarts the reset stretch
      clr_req = 1; run_req = 0;
      cyc();
      clr_req = 0;
      chk("clr_count", cycle_count, 0);
      chk("clr_state", state, 0);
      k = 0;
      while (cpu_reset_n !== 1'b1 && k < 20) begin
         cyc();
         k++;
      end
      chk("clr_stretch", k, RC);
      chk("clr_idle", state, 1);

      // halt after 25 enabled cycles
      limit = '0; run_req = 1;
      for (int i = 0; i < 100; i++) begin
         if (m_cnt == 25) halt_in = 1;
         settle();
         if (halt_in) begin
            chk("halt_ce_same", cpu_ce, 0);
            adv();
            break;
         end
         adv();
      end
      chk("halt_state", state, 3);
      chk("halt_count", cycle_count, 25);
      chk("halt_flags", {halted, timeout}, 2'b10);
      halt_in = 0; run_req = 0; clr_req = 1;
      cyc();
      clr_req = 0;
      wait_idle();

      // three held step requests
      n_ce = 0;
      repeat (3) begin
         step_req = 1;
         repeat (5) cyc();
         step_req = 0;
         repeat (3) cyc();
      end
      chk("step_pulses", n_ce, 3);
      chk("step_count", cycle_count, 3);
      chk("step_state", state, 1);

      // asynchronous reset mid-run
      run_req = 1;
      for (int i = 0; i < 50 && m_cnt != 7; i++) cyc();
      chk("pre_areset_count", cycle_count, 7);
      reset = 0;
      #1;
      chk("ar_state", state, 0);
      chk("ar_rstn", cpu_reset_n, 0);
      chk("ar_ce", cpu_ce, 0);
      chk("ar_count", cycle_count, 0);
      chk("ar_flags", {halted, timeout}, 0);
      m_reset();
      run_req = 0;
      @(posedge clk);
      #1;
      reset = 1;
      wait_idle();

      // random stimulus against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(7) == 0) run_req = ~run_req;
         step_req = ($urandom_range(2) == 0);
         clr_req  = ($urandom_range(30) == 0);
         halt_in  = ($urandom_range(25) == 0);
         if ($urandom_range(40) == 0) limit = CW'($urandom_range(30));
         cyc();
      end
      run_req = 0; step_req = 0; clr_req = 0; halt_in = 0;

      // 4-bit counter: saturation, then halt with limit together
      run4 = 1;
      repeat (20) cyc();
      chk("sat_count", cnt4, 15);
      chk("sat_ce", ce4, 1);
      chk("sat_state", st4, 2);
      run4 = 0; clr4 = 1;
      cyc();
      clr4 = 0;
      for (int i = 0; i < 20 && st4 != 2'd1; i++) cyc();
      chk("w4_idle", st4, 1);
      limit4 = 4'd5; run4 = 1;
      for (int i = 0; i < 40; i++) begin
         if (cnt4 == 4'd5) halt4 = 1;
         cyc();
         if (halt4) break;
      end
      chk("both_halt_seen", halt4, 1);
      chk("both_state", st4, 3);
      chk("both_count", cnt4, 5);
      chk("both_flags", {h4, t4}, 2'b10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/run_controller.md
# run_controller

Parametrised run-control unit placed between the top-level clock/reset and the CPU core. It generates a stretched CPU reset and a CPU clock enable, and supports three ways of advancing the CPU: continuous run, single-step, and run-to-cycle-limit. It stops the CPU on a halt indication or on a programmable cycle limit, and reports a cycle count. It replaces fixed-length reset and fixed simulation-timeout handling with a synthesizable, parameter-driven block usable in both simulation and hardware.

## Interface
- RESET_CYCLES, 4: clocks `cpu_reset_n` stays low after `reset` deasserts; minimum 1.
- CNT_WIDTH, 20: width of the cycle counter and of `limit`.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset of the whole block.
- run_req  in  1  level; 1 = run continuously, 0 = pause.
- step_req  in  1  synchronous; each rising edge requests one CPU cycle while paused.
- clr_req  in  1  synchronous; 1 = soft restart (re-enter RESET state, clear counter).
- halt_in  in  1  CPU halt indication, sampled every clock.
- limit  in  CNT_WIDTH  cycle limit; 0 = unlimited.
- cpu_reset_n  out  1  active-low reset to the CPU.
- cpu_ce  out  1  CPU clock enable; the CPU advances on each edge where this is 1.
- cycle_count  out  CNT_WIDTH  number of enabled CPU cycles since the last reset or clear.
- state  out  2  current state: 0 RESET, 1 IDLE, 2 RUN, 3 STOP.
- halted  out  1  sticky; the CPU stopped on `halt_in`.
- timeout  out  1  sticky; the CPU stopped on the cycle limit.

## Operation
- Reset values: state = RESET, `cpu_reset_n` = 0, `cpu_ce` = 0, `cycle_count` = 0, `halted` = 0, `timeout` = 0, reset-stretch counter = 0, step edge register = 0.
- Asserting `reset` at any time, including mid-run, forces all reset values immediately, without waiting for a clock edge.
- Limit hit: `lim_hit = (limit != 0) && (cycle_count == limit)`.
- RESET state:
  - `cpu_reset_n` = 0.
  - The stretch counter increments each clock.
  - When the counter reaches RESET_CYCLES-1, go to IDLE and drive `cpu_reset_n` to 1 (registered).
- IDLE state:
  - `cpu_ce` = 0 except for a step pulse.
  - `run_req` = 1 → RUN.
  - A `step_req` rising edge (step_req & ~step_q) with `halt_in` = 0 and `lim_hit` = 0 sets a registered one-clock `step_pulse`.
  - A step edge with `halt_in` = 1 → STOP, `halted` = 1.
  - A step edge with `lim_hit` = 1 → STOP, `timeout` = 1.
- RUN state:
  - `cpu_ce` = ~halt_in & ~lim_hit.
  - `halt_in` = 1 → STOP, `halted` = 1.
  - Otherwise, `lim_hit` → STOP, `timeout` = 1.
  - Otherwise, `run_req` = 0 → IDLE.
  - Step edges are ignored.
- STOP state:
  - `cpu_ce` = 0.
  - `halted` and `timeout` hold.
  - Only `clr_req` or `reset` leaves this state.
- `clr_req` = 1 in any state except RESET → RESET next edge. This clears `cycle_count`, `halted`, `timeout` and the stretch counter, and sets `cpu_reset_n` = 0.
- `clr_req` has priority over every other transition.
- `cpu_ce` = (state == RUN & ~halt_in & ~lim_hit) | step_pulse. This is a combinational decode of registered state and inputs.
- `cycle_count` increments on every edge where `cpu_ce` = 1. It saturates at all-ones and never wraps; with `limit` = 0 the run continues after saturation.
- `halt_in` and `lim_hit` true together: halt wins (`halted` = 1, `timeout` = 0).
- `halted` and `timeout` are never both 1.

## Timing
- The first `cpu_reset_n` = 1 occurs exactly RESET_CYCLES rising edges after `reset` deasserts.
- `run_req` rising in IDLE: state becomes RUN at the next edge, and `cpu_ce` is 1 in the following cycle.
- Step: `step_req` edge sampled at edge N; `step_pulse`/`cpu_ce` are high for exactly the cycle after edge N; `cycle_count` increments at edge N+1.
- `halt_in` high in RUN: `cpu_ce` drops in the same cycle (combinational), and STOP is entered at the next edge.
- Cycle limit: with `limit` = L, exactly L enabled cycles occur, and STOP is entered one edge after `cycle_count` reaches L.
- A held `step_req` produces one step only.

## Structure
- Package `run_ctrl_pkg`:
  - state encoding constants ST_RESET = 2'd0, ST_IDLE = 2'd1, ST_RUN = 2'd2, ST_STOP = 2'd3;
  - the width of the `state` field.
- One sub-module, `sat_counter`: a CNT_WIDTH-parameterised saturating up-counter with enable and synchronous clear, used for `cycle_count`.
- The reset stretcher and the FSM live in `run_controller`.

## Test plan
- Reset with RESET_CYCLES = 4 → `cpu_reset_n` low for exactly 4 edges after `reset` rises, state = 1 afterwards, all other outputs 0.
- `run_req` = 1, `limit` = 10 → exactly 10 `cpu_ce` cycles, `cycle_count` = 10, state = 3, `timeout` = 1, `halted` = 0.
- `run_req` = 1, `limit` = 0, `halt_in` raised after 25 enabled cycles → `cpu_ce` low in that same cycle, `cycle_count` = 25, `halted` = 1.
- Paused, three `step_req` pulses each held 5 clocks → three single-cycle `cpu_ce` pulses, `cycle_count` = 3, state stays 1.
- CNT_WIDTH = 4, `limit` = 0, run 20 cycles → `cycle_count` saturates at 15, `cpu_ce` stays 1; `halt_in` and `lim_hit` together (`limit` = 5 at count 5) → `halted` = 1, `timeout` = 0.
- `reset` asserted mid-RUN at count 7 → all outputs at reset values immediately; `clr_req` in STOP → counter 0, `cpu_reset_n` low for RESET_CYCLES edges, then IDLE.
